// File: rtl/inst_queue_param.sv
// In-order instruction queue between fetch and decode.
// Buffers fetched instructions with their PC and branch prediction and issues
// at most one per cycle. Issue stalls on decoder back-pressure, a full ROB, or
// a full target structure (LSB for loads/stores, RS for everything else).
// With BYPASS=1, an instruction arriving at an empty queue can issue in the
// same cycle without being written to storage.
module inst_queue_param #(
  parameter int DEPTH    = 16,
  parameter int INST_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int AF_SLACK = 2,
  parameter int BYPASS   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   rob_full,
  input  logic                   rs_full,
  input  logic                   lsb_full,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INST_W-1:0]      in_inst,
  input  logic [ADDR_W-1:0]      in_pc,
  input  logic                   in_pred_jump,
  input  logic [ADDR_W-1:0]      in_pred_pc,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   id_ready,
  output logic                   out_valid,
  output logic [INST_W-1:0]      out_inst,
  output logic [ADDR_W-1:0]      out_pc,
  output logic                   out_pred_jump,
  output logic [ADDR_W-1:0]      out_pred_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_SLACK);

  // Loads (0000011) and stores (0100011) go to the LSB; everything else to the RS.
  function automatic logic is_lsb_op(input logic [INST_W-1:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic              r_pj_mem   [DEPTH];
  logic [ADDR_W-1:0] r_ppc_mem  [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_out_valid;
  logic [INST_W-1:0] r_out_inst;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_out_pj;
  logic [ADDR_W-1:0] r_out_ppc;

  logic              w_enq;
  logic              w_head_cand;
  logic              w_byp_cand;
  logic              w_has_cand;
  logic [INST_W-1:0] w_cand_inst;
  logic [ADDR_W-1:0] w_cand_pc;
  logic              w_cand_pj;
  logic [ADDR_W-1:0] w_cand_ppc;
  logic              w_cand_lsb;
  logic              w_issue;
  logic              w_deq;
  logic              w_store;
  logic [CNT_W-1:0]  w_count_next;

  // Status flags depend only on occupancy, never on downstream stalls.
  assign in_ready    = (r_count < DEPTH_C);
  assign almost_full = (r_count >= AF_LEVEL);
  assign count       = r_count;

  assign out_valid     = r_out_valid;
  assign out_inst      = r_out_inst;
  assign out_pc        = r_out_pc;
  assign out_pred_jump = r_out_pj;
  assign out_pred_pc   = r_out_ppc;

  // Candidate selection, issue decision and occupancy bookkeeping.
  always_comb begin
    w_enq       = in_valid && in_ready;
    w_head_cand = (r_count != '0);
    w_byp_cand  = (BYPASS != 0) && !w_head_cand && w_enq;
    w_has_cand  = w_head_cand || w_byp_cand;
    w_cand_inst = in_inst;
    w_cand_pc   = in_pc;
    w_cand_pj   = in_pred_jump;
    w_cand_ppc  = in_pred_pc;
    if (w_head_cand) begin
      w_cand_inst = r_inst_mem[r_head];
      w_cand_pc   = r_pc_mem[r_head];
      w_cand_pj   = r_pj_mem[r_head];
      w_cand_ppc  = r_ppc_mem[r_head];
    end
    w_cand_lsb   = is_lsb_op(w_cand_inst);
    w_issue      = w_has_cand && id_ready && !rob_full &&
                   (w_cand_lsb ? !lsb_full : !rs_full);
    // A bypassed instruction never touches storage, so it is neither stored
    // nor dequeued.
    w_deq        = w_issue && w_head_cand;
    w_store      = w_enq && !(w_issue && w_byp_cand);
    w_count_next = r_count + CNT_W'(w_store) - CNT_W'(w_deq);
  end

  // Entry storage: written at tail on a stored enqueue; no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && !flush && rdy && w_store) begin
      r_inst_mem[r_tail] <= in_inst;
      r_pc_mem[r_tail]   <= in_pc;
      r_pj_mem[r_tail]   <= in_pred_jump;
      r_ppc_mem[r_tail]  <= in_pred_pc;
    end
  end

  // Pointers, occupancy and issue register: rst > flush > !rdy > normal.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_out_pj    <= 1'b0;
      r_out_ppc   <= '0;
    end else if (flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (rdy) begin
      if (w_store) r_tail <= r_tail + 1'b1;
      if (w_deq)   r_head <= r_head + 1'b1;
      r_count     <= w_count_next;
      r_out_valid <= w_issue;
      if (w_issue) begin
        r_out_inst <= w_cand_inst;
        r_out_pc   <= w_cand_pc;
        r_out_pj   <= w_cand_pj;
        r_out_ppc  <= w_cand_ppc;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue_param.sv
// Directed bench for inst_queue_param: one DEPTH=4 instance without bypass and
// one with bypass share the stimulus; a reference model predicts issue and
// occupancy, and a scoreboard holds accepted instructions in issue order.
module tb_inst_queue_param;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, rob_full, rs_full, lsb_full;
  logic        in_valid, in_pred_jump, id_ready;
  logic [31:0] in_inst, in_pc, in_pred_pc;
  logic        sel;

  logic        o0_in_ready, o0_af, o0_out_valid, o0_out_pj;
  logic [2:0]  o0_count;
  logic [31:0] o0_out_inst, o0_out_pc, o0_out_ppc;
  logic        o1_in_ready, o1_af, o1_out_valid, o1_out_pj;
  logic [2:0]  o1_count;
  logic [31:0] o1_out_inst, o1_out_pc, o1_out_ppc;

  logic        w_in_ready, w_af, w_out_valid, w_out_pj;
  logic [2:0]  w_count;
  logic [31:0] w_out_inst, w_out_pc, w_out_ppc;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t mq[$];
  ent_t sb_q[$];
  logic exp_ov;
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  inst_queue_param #(.DEPTH(4), .INST_W(32), .ADDR_W(32), .AF_SLACK(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rob_full(rob_full),
    .rs_full(rs_full), .lsb_full(lsb_full), .in_valid(in_valid),
    .in_ready(o0_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_pred_jump(in_pred_jump), .in_pred_pc(in_pred_pc),
    .almost_full(o0_af), .count(o0_count), .id_ready(id_ready),
    .out_valid(o0_out_valid), .out_inst(o0_out_inst), .out_pc(o0_out_pc),
    .out_pred_jump(o0_out_pj), .out_pred_pc(o0_out_ppc)
  );

  inst_queue_param #(.DEPTH(4), .INST_W(32), .ADDR_W(32), .AF_SLACK(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .rob_full(rob_full),
    .rs_full(rs_full), .lsb_full(lsb_full), .in_valid(in_valid),
    .in_ready(o1_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_pred_jump(in_pred_jump), .in_pred_pc(in_pred_pc),
    .almost_full(o1_af), .count(o1_count), .id_ready(id_ready),
    .out_valid(o1_out_valid), .out_inst(o1_out_inst), .out_pc(o1_out_pc),
    .out_pred_jump(o1_out_pj), .out_pred_pc(o1_out_ppc)
  );

  assign w_in_ready  = sel ? o1_in_ready  : o0_in_ready;
  assign w_af        = sel ? o1_af        : o0_af;
  assign w_count     = sel ? o1_count     : o0_count;
  assign w_out_valid = sel ? o1_out_valid : o0_out_valid;
  assign w_out_inst  = sel ? o1_out_inst  : o0_out_inst;
  assign w_out_pc    = sel ? o1_out_pc    : o0_out_pc;
  assign w_out_pj    = sel ? o1_out_pj    : o0_out_pj;
  assign w_out_ppc   = sel ? o1_out_ppc   : o0_out_ppc;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc, input logic [6:0] op);
    return {pc[19:0], 5'd0, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [6:0] op);
    in_valid     = v;
    in_pc        = pc;
    in_inst      = mk_inst(pc, op);
    in_pred_jump = pc[2];
    in_pred_pc   = pc ^ 32'hFFFF_0000;
  endtask

  // One clock: predict from the model, advance the clock, compare.
  task automatic tick();
    ent_t e, c;
    logic acc, iss, hc, lsb, fresh, quiet;
    e.inst = in_inst;
    e.pc   = in_pc;
    chk("in_ready", w_in_ready, mq.size() < 4);
    chk("almost_full", w_af, mq.size() >= 2);
    acc   = in_valid && (mq.size() < 4);
    fresh = 1'b0;
    quiet = 1'b0;
    if (rst) begin
      mq.delete();
      sb_q.delete();
      exp_ov  = 1'b0;
      last_pc = '0;
    end else if (flush) begin
      mq.delete();
      sb_q.delete();
      exp_ov = 1'b0;
      quiet  = 1'b1;
    end else if (rdy) begin
      hc  = (mq.size() > 0);
      iss = 1'b0;
      if (hc || (sel && acc)) begin
        c   = hc ? mq[0] : e;
        lsb = (c.inst[6:0] == 7'h03) || (c.inst[6:0] == 7'h23);
        iss = id_ready && !rob_full && !(lsb ? lsb_full : rs_full);
      end
      if (acc) sb_q.push_back(e);
      if (iss && hc) void'(mq.pop_front());
      if (acc && !(iss && !hc)) mq.push_back(e);
      exp_ov = iss;
      fresh  = iss;
    end
    @(posedge clk);
    #1;
    chk("out_valid", w_out_valid, exp_ov);
    chk("count", w_count, mq.size());
    if (w_out_valid && fresh) begin
      n_chk++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL sb_underflow: observed out_pc %0h expected no output", w_out_pc);
      end
      if (sb_q.size() != 0) begin
        c = sb_q.pop_front();
        chk("out_pc", w_out_pc, c.pc);
        chk("out_inst", w_out_inst, c.inst);
        chk("out_pred_pc", w_out_ppc, c.pc ^ 32'hFFFF_0000);
        chk("out_pred_jump", w_out_pj, c.pc[2]);
        last_pc = c.pc;
      end
    end else if (!quiet) begin
      chk("out_pc_hold", w_out_pc, last_pc);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && mq.size() != 0; i++) tick();
    tick();
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 7'h13);
    exp_ov = 1'b0; last_pc = '0;
    #1;
    tick();
    rst = 1'b0;

    // Fill past full with decoder stalled; fifth offer is refused.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i * 4), 7'h13);
      tick();
    end
    drive(1'b0, 32'h0, 7'h13);
    tick();
    // Release the decoder: 0x00..0x0C issue in order, head wraps.
    id_ready = 1'b1;
    drain();

    // Load at head blocked by lsb_full holds back a younger RS instruction.
    id_ready = 1'b0;
    drive(1'b1, 32'h20, 7'h03); tick();
    drive(1'b1, 32'h24, 7'h33); tick();
    drive(1'b0, 32'h0, 7'h13);
    id_ready = 1'b1; lsb_full = 1'b1;
    tick(); tick(); tick();
    lsb_full = 1'b0; rob_full = 1'b1;
    tick();
    rob_full = 1'b0; rs_full = 1'b1;
    tick(); tick();
    rs_full = 1'b0;
    drain();

    // Steady one-per-cycle stream with the decoder always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h30 + 32'(i * 4), 7'h13);
      tick();
    end
    drive(1'b0, 32'h0, 7'h13);
    drain();

    // Freeze with rdy=0, then flush three pending entries plus an offer.
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(i * 4), 7'h23);
      tick();
    end
    rdy = 1'b0; id_ready = 1'b1;
    drive(1'b1, 32'h90, 7'h13);
    tick(); tick();
    rdy = 1'b1; flush = 1'b1; id_ready = 1'b0;
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h100, 7'h13); tick();
    drive(1'b1, 32'h104, 7'h13); id_ready = 1'b1; tick();
    drive(1'b0, 32'h0, 7'h13);
    drain();

    // Bypass instance: empty-queue arrival issues on the next edge.
    sel = 1'b1; rst = 1'b1; id_ready = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h40, 7'h13); tick();
    drive(1'b0, 32'h0, 7'h13); tick();
    rdy = 1'b0;
    drive(1'b1, 32'h44, 7'h13); tick();
    rdy = 1'b1;
    drive(1'b0, 32'h0, 7'h13); tick();
    // Bypass candidate blocked by rs_full is stored instead, then issues.
    rs_full = 1'b1;
    drive(1'b1, 32'h48, 7'h13); tick();
    rs_full = 1'b0;
    drive(1'b1, 32'h4C, 7'h03); tick();
    drive(1'b0, 32'h0, 7'h13);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
